// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner: scans a 4x4 active-low membrane keypad one row at a
// time, debounces press and release on scan ticks, and presents the held key
// as a one-hot code plus a binary key index and a one-cycle accept pulse.

module keypad_matrix_scanner #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  col_in,
    output logic [3:0]  row_out,
    output logic [15:0] onehot,
    output logic [3:0]  key_code,
    output logic        key_valid
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DEB_W = $clog2(DEBOUNCE_TICKS + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_DONE = DEB_W'(DEBOUNCE_TICKS);
    localparam logic [DEB_W-1:0] DEB_ONE  = DEB_W'(1);

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        PRESSED,
        RELEASE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [3:0]       col_m;
    logic [3:0]       col_s;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [1:0]       row_idx;
    logic [1:0]       row_next;
    logic [1:0]       col_idx;
    logic [1:0]       col_next;
    logic [DEB_W-1:0] deb_cnt;
    logic [DEB_W-1:0] deb_next;
    logic [DEB_W-1:0] deb_inc;
    logic             single_press;
    logic [1:0]       press_col;
    logic [3:0]       latched_pattern;
    logic             latched_high;
    logic [15:0]      onehot_next;
    logic [3:0]       key_code_next;
    logic             key_valid_next;

    // Two-flop synchronizer on the asynchronous column pins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_m <= 4'b1111;
            col_s <= 4'b1111;
        end else begin
            col_m <= col_in;
            col_s <= col_m;
        end
    end

    // Scan-rate divider; tick marks the last count of each period
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    assign tick            = (div_cnt == DIV_LAST);
    assign deb_inc         = deb_cnt + DEB_ONE;
    assign latched_pattern = ~(4'b0001 << col_idx);
    assign latched_high    = col_s[col_idx];

    // Classify the sampled columns: exactly one low bit is a valid press
    always_comb begin
        single_press = 1'b0;
        press_col    = 2'd0;
        case (col_s)
            4'b1110: begin single_press = 1'b1; press_col = 2'd0; end
            4'b1101: begin single_press = 1'b1; press_col = 2'd1; end
            4'b1011: begin single_press = 1'b1; press_col = 2'd2; end
            4'b0111: begin single_press = 1'b1; press_col = 2'd3; end
            default: begin single_press = 1'b0; press_col = 2'd0; end
        endcase
    end

    // State register with the row, column and debounce bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= SCAN;
            row_idx <= 2'd0;
            col_idx <= 2'd0;
            deb_cnt <= '0;
            row_out <= 4'b1110;
        end else begin
            state   <= state_next;
            row_idx <= row_next;
            col_idx <= col_next;
            deb_cnt <= deb_next;
            row_out <= ~(4'b0001 << row_next);
        end
    end

    // Next-state decisions, evaluated only on scan ticks
    always_comb begin
        state_next = state;
        row_next   = row_idx;
        col_next   = col_idx;
        deb_next   = deb_cnt;
        if (tick) begin
            case (state)
                SCAN: begin
                    if (single_press) begin
                        col_next   = press_col;
                        deb_next   = DEB_ONE;
                        state_next = DEBOUNCE;
                    end else begin
                        row_next = row_idx + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (col_s == latched_pattern) begin
                        deb_next = deb_inc;
                        if (deb_inc == DEB_DONE) begin
                            state_next = PRESSED;
                        end
                    end else begin
                        state_next = SCAN;
                        row_next   = row_idx + 2'd1;
                        deb_next   = '0;
                    end
                end
                PRESSED: begin
                    if (latched_high) begin
                        state_next = RELEASE;
                        deb_next   = DEB_ONE;
                    end
                end
                RELEASE: begin
                    if (latched_high) begin
                        deb_next = deb_inc;
                        if (deb_inc == DEB_DONE) begin
                            state_next = SCAN;
                            row_next   = row_idx + 2'd1;
                            deb_next   = '0;
                        end
                    end else begin
                        state_next = PRESSED;
                        deb_next   = '0;
                    end
                end
                default: begin
                    state_next = SCAN;
                    deb_next   = '0;
                end
            endcase
        end
    end

    // Output decode: load the key on acceptance, clear onehot on full release
    always_comb begin
        onehot_next    = onehot;
        key_code_next  = key_code;
        key_valid_next = 1'b0;
        if (state == DEBOUNCE && state_next == PRESSED) begin
            onehot_next    = 16'h0001 << {row_idx, col_idx};
            key_code_next  = {row_idx, col_idx};
            key_valid_next = 1'b1;
        end else if (state == RELEASE && state_next == SCAN) begin
            onehot_next = '0;
        end
    end

    // Registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            onehot    <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
        end else begin
            onehot    <= onehot_next;
            key_code  <= key_code_next;
            key_valid <= key_valid_next;
        end
    end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// tb_keypad_matrix_scanner: keypad model plus scoreboard of expected accepted
// keys; each scenario task drives the keypad and checks its own results.

module tb_keypad_matrix_scanner;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 3;
    localparam int TICK     = SCAN_DIV;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  col_in;
    logic [3:0]  row_out;
    logic [15:0] onehot;
    logic [3:0]  key_code;
    logic        key_valid;
    logic [15:0] pressed = 16'h0000;

    int checks      = 0;
    int failures    = 0;
    int valid_count = 0;

    typedef struct {
        logic [15:0] onehot;
        logic [3:0]  code;
    } exp_t;

    exp_t sb[$];
    exp_t mon_exp;

    keypad_matrix_scanner #(
        .SCAN_DIV      (SCAN_DIV),
        .DEBOUNCE_TICKS(DEB)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .col_in   (col_in),
        .row_out  (row_out),
        .onehot   (onehot),
        .key_code (key_code),
        .key_valid(key_valid)
    );

    always #5 clk = ~clk;

    // Keypad model: a held key grounds its column while its row is driven low
    always_comb begin
        col_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!row_out[r] && pressed[r*4+c]) begin
                    col_in[c] = 1'b0;
                end
            end
        end
    end

    // Scoreboard monitor: every key_valid pops and compares one expectation
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if ($countones(onehot) > 1) begin
                failures++;
                $display("[TB] FAIL onehot_multihot actual=%h required=at most one bit set", onehot);
            end
            if (key_valid) begin
                valid_count++;
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL unexpected_key_valid actual onehot=%h code=%h required=no pulse",
                             onehot, key_code);
                end else begin
                    mon_exp = sb.pop_front();
                    if (onehot !== mon_exp.onehot || key_code !== mon_exp.code) begin
                        failures++;
                        $display("[TB] FAIL accepted_key actual onehot=%h code=%h required onehot=%h code=%h",
                                 onehot, key_code, mon_exp.onehot, mon_exp.code);
                    end
                end
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_drain(input int max_cycles);
        for (int i = 0; i < max_cycles && sb.size() > 0; i++) @(negedge clk);
    endtask

    task automatic wait_clear(input int max_cycles);
        for (int i = 0; i < max_cycles && onehot !== 16'h0000; i++) @(negedge clk);
    endtask

    task automatic test_reset;
        int n;
        logic [3:0] exp_row;
        $display("[TB] test_reset");
        rst_n   = 1'b0;
        pressed = 16'h0000;
        wait_cycles(3);
        checks++;
        if (row_out !== 4'b1110) begin failures++; $display("[TB] FAIL reset_row actual=%b required=1110", row_out); end
        checks++;
        if (onehot !== 16'h0000) begin failures++; $display("[TB] FAIL reset_onehot actual=%h required=0000", onehot); end
        checks++;
        if (key_code !== 4'h0) begin failures++; $display("[TB] FAIL reset_code actual=%h required=0", key_code); end
        checks++;
        if (key_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid actual=%b required=0", key_valid); end
        rst_n = 1'b1;
        n = 0;
        while (row_out === 4'b1110 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (row_out === 4'b1110) begin failures++; $display("[TB] FAIL rotate_start actual=%b required=row change", row_out); end
        for (int k = 1; k <= 8; k++) begin
            exp_row = ~(4'b0001 << (k % 4));
            for (int j = 0; j < 4; j++) begin
                checks++;
                if (row_out !== exp_row) begin
                    failures++;
                    $display("[TB] FAIL row_rotation actual=%b required=%b", row_out, exp_row);
                end
                @(negedge clk);
            end
        end
        checks++;
        if (valid_count !== 0 || onehot !== 16'h0000) begin
            failures++;
            $display("[TB] FAIL idle_no_key actual valid=%0d onehot=%h required valid=0 onehot=0000", valid_count, onehot);
        end
    endtask

    task automatic test_hold;
        int v0;
        logic [3:0] r0;
        $display("[TB] test_hold");
        v0 = valid_count;
        sb.push_back('{16'h0200, 4'h9});
        pressed = 16'h0200;
        wait_cycles(40 * TICK);
        checks++;
        if (sb.size() != 0) begin failures++; $display("[TB] FAIL hold_accept actual pending=%0d required=0", sb.size()); sb.delete(); end
        checks++;
        if (onehot !== 16'h0200) begin failures++; $display("[TB] FAIL hold_onehot actual=%h required=0200", onehot); end
        checks++;
        if (key_code !== 4'h9) begin failures++; $display("[TB] FAIL hold_code actual=%h required=9", key_code); end
        checks++;
        if (row_out !== 4'b1011) begin failures++; $display("[TB] FAIL hold_row_frozen actual=%b required=1011", row_out); end
        checks++;
        if (valid_count - v0 != 1) begin failures++; $display("[TB] FAIL hold_pulses actual=%0d required=1", valid_count - v0); end
        pressed = 16'h0000;
        wait_cycles(6 * TICK);
        checks++;
        if (onehot !== 16'h0000) begin failures++; $display("[TB] FAIL release_onehot actual=%h required=0000", onehot); end
        checks++;
        if (key_code !== 4'h9) begin failures++; $display("[TB] FAIL release_code_held actual=%h required=9", key_code); end
        r0 = row_out;
        wait_cycles(TICK);
        checks++;
        if (row_out !== {r0[2:0], r0[3]}) begin
            failures++;
            $display("[TB] FAIL release_rotation actual=%b required=%b", row_out, {r0[2:0], r0[3]});
        end
    endtask

    task automatic test_bounce;
        int v0;
        $display("[TB] test_bounce");
        v0 = valid_count;
        for (int i = 0; i < 10; i++) begin
            pressed = (i % 2 == 0) ? 16'h0001 : 16'h0000;
            wait_cycles(TICK);
        end
        checks++;
        if (valid_count != v0 || onehot !== 16'h0000) begin
            failures++;
            $display("[TB] FAIL bounce_quiet actual pulses=%0d onehot=%h required pulses=0 onehot=0000", valid_count - v0, onehot);
        end
        sb.push_back('{16'h0001, 4'h0});
        pressed = 16'h0001;
        wait_drain(40 * TICK);
        checks++;
        if (sb.size() != 0) begin failures++; $display("[TB] FAIL bounce_accept actual pending=%0d required=0", sb.size()); sb.delete(); end
        wait_cycles(2);
        checks++;
        if (onehot !== 16'h0001 || valid_count - v0 != 1) begin
            failures++;
            $display("[TB] FAIL bounce_stable actual onehot=%h pulses=%0d required onehot=0001 pulses=1", onehot, valid_count - v0);
        end
        pressed = 16'h0000;
        wait_clear(10 * TICK);
        checks++;
        if (onehot !== 16'h0000) begin failures++; $display("[TB] FAIL bounce_release actual=%h required=0000", onehot); end
    endtask

    task automatic test_invalid;
        int v0;
        logic [3:0] seen;
        $display("[TB] test_invalid");
        v0      = valid_count;
        seen    = 4'h0;
        pressed = 16'h0090;
        for (int i = 0; i < 20 * TICK; i++) begin
            @(negedge clk);
            seen = seen | ~row_out;
        end
        checks++;
        if (seen !== 4'hF) begin failures++; $display("[TB] FAIL invalid_rotation actual rows=%b required=1111", seen); end
        checks++;
        if (onehot !== 16'h0000 || valid_count != v0) begin
            failures++;
            $display("[TB] FAIL invalid_ignored actual onehot=%h pulses=%0d required onehot=0000 pulses=0", onehot, valid_count - v0);
        end
        pressed = 16'h0000;
        wait_cycles(2 * TICK);
    endtask

    task automatic test_glitch;
        int v0;
        int bad;
        $display("[TB] test_glitch");
        v0 = valid_count;
        sb.push_back('{16'h8000, 4'hF});
        pressed = 16'h8000;
        wait_drain(40 * TICK);
        checks++;
        if (sb.size() != 0) begin failures++; $display("[TB] FAIL glitch_accept actual pending=%0d required=0", sb.size()); sb.delete(); end
        wait_cycles(2 * TICK);
        pressed = 16'h0000;
        wait_cycles(TICK);
        pressed = 16'h8000;
        bad = 0;
        for (int i = 0; i < 10 * TICK; i++) begin
            @(negedge clk);
            if (onehot !== 16'h8000) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("[TB] FAIL glitch_hold actual bad_cycles=%0d onehot=%h required=8000", bad, onehot); end
        checks++;
        if (valid_count - v0 != 1) begin failures++; $display("[TB] FAIL glitch_pulses actual=%0d required=1", valid_count - v0); end
        pressed = 16'h0000;
        wait_clear(10 * TICK);
        checks++;
        if (onehot !== 16'h0000) begin failures++; $display("[TB] FAIL glitch_release actual=%h required=0000", onehot); end
    endtask

    task automatic test_reset_mid;
        int v1;
        $display("[TB] test_reset_mid");
        sb.push_back('{16'h0040, 4'h6});
        pressed = 16'h0040;
        wait_drain(40 * TICK);
        checks++;
        if (sb.size() != 0 || onehot !== 16'h0040) begin
            failures++;
            $display("[TB] FAIL midreset_setup actual pending=%0d onehot=%h required pending=0 onehot=0040", sb.size(), onehot);
            sb.delete();
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (onehot !== 16'h0000) begin failures++; $display("[TB] FAIL midreset_onehot actual=%h required=0000", onehot); end
        checks++;
        if (row_out !== 4'b1110) begin failures++; $display("[TB] FAIL midreset_row actual=%b required=1110", row_out); end
        checks++;
        if (key_code !== 4'h0 || key_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midreset_code actual code=%h valid=%b required code=0 valid=0", key_code, key_valid);
        end
        wait_cycles(3);
        rst_n = 1'b1;
        v1 = valid_count;
        sb.push_back('{16'h0040, 4'h6});
        wait_drain(40 * TICK);
        checks++;
        if (sb.size() != 0) begin failures++; $display("[TB] FAIL redetect actual pending=%0d required=0", sb.size()); sb.delete(); end
        wait_cycles(2);
        checks++;
        if (onehot !== 16'h0040 || valid_count - v1 != 1) begin
            failures++;
            $display("[TB] FAIL redetect_state actual onehot=%h pulses=%0d required onehot=0040 pulses=1", onehot, valid_count - v1);
        end
        pressed = 16'h0000;
        wait_clear(10 * TICK);
        checks++;
        if (onehot !== 16'h0000) begin failures++; $display("[TB] FAIL redetect_release actual=%h required=0000", onehot); end
    endtask

    initial begin
        test_reset();
        test_hold();
        test_bounce();
        test_invalid();
        test_glitch();
        test_reset_mid();
        wait_cycles(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keypad_matrix_scanner.md
Name: keypad_matrix_scanner

Overview:
Scans a 4x4 membrane keypad and produces the 16-bit one-hot key code consumed by the password/display encoder.
- Drives one row low at a time and samples the pulled-up column inputs.
- Debounces both press and release.
- Holds a single one-hot bit for as long as the key stays pressed.
- Sits between the board keypad pins and the onehot input of the password logic.

Parameters:
SCAN_DIV, 50000, clk cycles per scan tick (1 ms at 50 MHz); must be >= 2
DEBOUNCE_TICKS, 4, consecutive agreeing scan ticks needed to accept a press or a release; must be >= 2

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
col_in  input  4  keypad columns; asynchronous, active low, externally pulled up
row_out  output  4  keypad row drive; active low, exactly one bit low at all times
onehot  output  16  one-hot code of the held key; all zeros when no key is held
key_code  output  4  binary index of the last accepted key (row*4+col)
key_valid  output  1  one-cycle pulse when a new press is accepted

Behaviour:
- Reset (asynchronous, rst_n low) values:
  - row_out=4'b1110; onehot=0; key_code=0; key_valid=0
  - state=SCAN; divider, debounce counter, row index, latched col index = 0
  - synchronizer flops = 4'b1111
- col_in passes through a 2-flop synchronizer (col_s) before any use.
- Divider counts 0..SCAN_DIV-1 and wraps. tick is high for one cycle when the count equals SCAN_DIV-1. All state decisions happen only on tick.
- Row rotation: row_idx 0->1->2->3->0, giving row_out 1110->1101->1011->0111->1110. Row advances on a tick only in SCAN when no valid press is seen, and on the tick that leaves DEBOUNCE or RELEASE toward SCAN. Row is frozen in DEBOUNCE, PRESSED and RELEASE.
- "Single press" = col_s has exactly one bit low. Patterns with 2+ bits low are invalid and treated as no press.
- SCAN, on tick:
  - Single press: latch col_idx, deb_cnt=1, go to DEBOUNCE.
  - Otherwise: advance row.
- DEBOUNCE, on tick:
  - col_s equals the latched single-low pattern: deb_cnt+1. If the new value equals DEBOUNCE_TICKS, go to PRESSED.
  - Anything else: go to SCAN, advance row, deb_cnt=0.
- Entering PRESSED (registered, the cycle after the accepting tick):
  - onehot = 1 << (row_idx*4+col_idx)
  - key_code = row_idx*4+col_idx
  - key_valid = 1 for exactly that one cycle
- PRESSED, on tick: if the latched column is high, go to RELEASE with deb_cnt=1. Otherwise stay.
- RELEASE, on tick:
  - Latched column high: deb_cnt+1. When it reaches DEBOUNCE_TICKS, go to SCAN, clear onehot, advance row.
  - Latched column low: back to PRESSED, deb_cnt=0, no new key_valid.
- onehot remains asserted throughout RELEASE.
- key_code holds its value after release until the next accepted press.
- A second key pressed while in PRESSED (other column on the same row, or any other row) is ignored. The other column's bits are don't-care; only the latched column is checked.
- Press latency from stable col_in low (row already active): 2 sync cycles, plus up to SCAN_DIV cycles to the first tick, plus (DEBOUNCE_TICKS-1)*SCAN_DIV, plus 1 cycle.
- Reset mid-operation: all outputs return to reset values immediately, with no key_valid.
- onehot is never multi-hot.
- key_valid never asserts without onehot becoming nonzero in the same cycle.

Test Plan (bench uses SCAN_DIV=4, DEBOUNCE_TICKS=3; keypad model grounds col when its row is driven low):
- Reset release, no keys -> row_out cycles 1110,1101,1011,0111 with 4 clk per row; onehot=0; key_valid never high.
- Hold key row2/col1 for 40 ticks -> onehot=16'h0200, key_code=4'h9, exactly one key_valid pulse, row_out frozen at 1011; after release plus 3 ticks onehot=0 and row rotation resumes.
- Key row0/col0 bouncing low/high on alternate ticks for 10 ticks then stable -> no output during bounce; single key_valid with onehot=16'h0001 once stable for 3 ticks.
- Row1 with col0 and col3 both low -> treated as no press; rows keep rotating; onehot stays 0.
- Key row3/col3 held, one-tick release glitch -> enters RELEASE, returns to PRESSED; onehot stays 16'h8000 with no second key_valid.
- rst_n pulsed low while onehot=16'h0040 -> onehot=0, row_out=1110, key_code=0 asynchronously; after reset the still-held key is re-detected with a fresh key_valid.
